// File: rtl/hw_accel_pkg.sv
// Shared types and helpers for the hw_accel pixel pipeline.
// Window tap layout and the 3x3 window FSM state encoding.
package hw_accel_pkg;

  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } win_state_e;

  function automatic int tap_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/hw_accel_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Contents are never reset; consumers mask stale data.
module hw_accel_line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/hw_accel_window_3x3.sv
// Raster stream to 3x3 neighbourhood generator with frame-edge padding.
// Two line RAMs plus a 2-column shift register; self-flushes the frame tail.
module hw_accel_window_3x3
  import hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PAD_VALUE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         pixel_in,
  input  logic                          pixel_in_valid,
  output logic                          pixel_in_ready,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] win_data,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic                          win_last
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 2);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FL_MAX  = FW'(IMG_WIDTH);
  localparam logic [DW-1:0] PAD     = DW'(PAD_VALUE);

  win_state_e state, state_nx;

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [FW-1:0] fl_cnt;

  logic          accept;
  logic          vfire;
  logic          fire0;
  logic          emit0;
  logic          in_last;
  logic [CW-1:0] rd_addr;

  logic          fire1;
  logic          emit1;
  logic          wr1;
  logic [CW-1:0] col_d;
  logic [DW-1:0] pix_d;

  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;

  logic [2:0][DW-1:0] sr_a;
  logic [2:0][DW-1:0] sr_b;
  logic [2:0][DW-1:0] col_new;

  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_last;

  logic [WIN_TAPS*DW-1:0] win_nx;

  assign pixel_in_ready = (state != ST_FLUSH);
  assign accept  = pixel_in_valid && pixel_in_ready;
  assign in_last = (in_row == ROW_MAX) && (in_col == COL_MAX);

  // Flush replays W+1 virtual pixels past the frame end.
  assign vfire = (state == ST_FLUSH) && (fl_cnt <= FL_MAX);
  assign fire0 = accept || vfire;
  assign emit0 = (accept && state == ST_RUN) || vfire;

  always_comb begin
    rd_addr = in_col;
    if (vfire) begin
      rd_addr = (fl_cnt == FL_MAX) ? '0 : CW'(fl_cnt);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_FILL: begin
        if (accept && in_row == RW'(1) && in_col == '0) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && in_last) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (win_last) begin
          state_nx = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (in_col == COL_MAX) begin
        in_col <= '0;
        in_row <= (in_row == ROW_MAX) ? '0 : in_row + RW'(1);
      end else begin
        in_col <= in_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_cnt <= '0;
    end else if (state != ST_FLUSH) begin
      fl_cnt <= '0;
    end else if (vfire) begin
      fl_cnt <= fl_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire1 <= 1'b0;
      emit1 <= 1'b0;
      wr1   <= 1'b0;
      col_d <= '0;
      pix_d <= '0;
    end else begin
      fire1 <= fire0;
      emit1 <= emit0;
      wr1   <= accept;
      col_d <= rd_addr;
      if (accept) begin
        pix_d <= pixel_in;
      end
    end
  end

  // line1 holds the previous row, line0 the one before; line1 cascades down.
  hw_accel_line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DW)
  ) u_line0 (
    .clk     (clk),
    .wr_en   (wr1),
    .wr_addr (col_d),
    .wr_data (rd1),
    .rd_en   (fire0),
    .rd_addr (rd_addr),
    .rd_data (rd0)
  );

  hw_accel_line_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DW)
  ) u_line1 (
    .clk     (clk),
    .wr_en   (wr1),
    .wr_addr (col_d),
    .wr_data (pix_d),
    .rd_en   (fire0),
    .rd_addr (rd_addr),
    .rd_data (rd1)
  );

  assign col_new  = {pix_d, rd1, rd0};
  assign out_last = (out_row == ROW_MAX) && (out_col == COL_MAX);

  always_comb begin
    win_nx = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        logic [DW-1:0] tap;
        logic          pad;
        tap = col_new[r];
        if (c == 0) begin
          tap = sr_a[r];
        end else if (c == 1) begin
          tap = sr_b[r];
        end
        pad = (r == 0 && out_row == '0)
           || (r == 2 && out_row == ROW_MAX)
           || (c == 0 && out_col == '0)
           || (c == 2 && out_col == COL_MAX);
        win_nx[tap_idx(r, c)*DW +: DW] = pad ? PAD : tap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_a <= '0;
      sr_b <= '0;
    end else if (fire1) begin
      sr_a <= sr_b;
      sr_b <= col_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
      win_col   <= '0;
      win_row   <= '0;
      out_col   <= '0;
      out_row   <= '0;
    end else begin
      win_valid <= emit1;
      win_last  <= emit1 && out_last;
      if (emit1) begin
        win_data <= win_nx;
        win_col  <= out_col;
        win_row  <= out_row;
        if (out_col == COL_MAX) begin
          out_col <= '0;
          out_row <= (out_row == ROW_MAX) ? '0 : out_row + RW'(1);
        end else begin
          out_col <= out_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hw_accel_window_3x3.sv
// Bench for hw_accel_window_3x3: W=4, H=3 frames checked against a
// 2-D padded-neighbourhood model plus hand-computed windows.
module tb_hw_accel_window_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int N  = W * H;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic        pixel_in_ready;
  logic [71:0] win_data;
  logic        win_valid;
  logic [1:0]  win_col;
  logic [1:0]  win_row;
  logic        win_last;

  hw_accel_window_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PAD_VALUE  (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_ready (pixel_in_ready),
    .win_data       (win_data),
    .win_valid      (win_valid),
    .win_col        (win_col),
    .win_row        (win_row),
    .win_last       (win_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_acc = 0;
  int out_idx = 0;
  int frames_done = 0;
  bit ready_chk = 1'b0;

  int          acc_cyc [N];
  logic [7:0]  img [N];
  logic [71:0] got [N];

  function automatic logic [71:0] ref_win(input int k);
    logic [71:0] w;
    int r0, c0, rr, cc;
    w  = '0;
    r0 = k / W;
    c0 = k % W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r0 + dr;
        cc = c0 + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
          w[(3*(dr+1) + (dc+1))*8 +: 8] = img[rr*W + cc];
        end
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] w9(input int t0, input int t1,
      input int t2, input int t3, input int t4, input int t5,
      input int t6, input int t7, input int t8);
    return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4),
            8'(t3), 8'(t2), 8'(t1), 8'(t0)};
  endfunction

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model's schedule and contents.
  always @(negedge clk) begin
    bit due;
    int trig;
    cyc++;
    if (rst) begin
      n_acc = 0;
      out_idx = 0;
      ready_chk = 1'b0;
      tests++;
      if (win_valid !== 1'b0 || win_data !== '0 || win_col !== '0 ||
          win_row !== '0 || win_last !== 1'b0 || pixel_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_state: valid=%b data=%h col=%0d row=%0d last=%b rdy=%b",
                 win_valid, win_data, win_col, win_row, win_last, pixel_in_ready);
      end
    end else begin
      due = 1'b0;
      if (out_idx <= N - W - 2) begin
        trig = out_idx + W + 1;
        if (trig < n_acc) due = (cyc == acc_cyc[trig] + 2);
      end else if (n_acc == N) begin
        due = (cyc == acc_cyc[N-1] + 2 + (out_idx - (N - W - 2)));
      end
      tests++;
      if (win_valid !== due) begin
        fails++;
        $display("FAIL win_valid_timing: cyc=%0d win=%0d got %b want %b",
                 cyc, out_idx, win_valid, due);
      end
      if (due && win_valid) begin
        got[out_idx] = win_data;
        tests++;
        if (win_data !== ref_win(out_idx) || win_col !== 2'(out_idx % W) ||
            win_row !== 2'(out_idx / W) || win_last !== (out_idx == N - 1)) begin
          fails++;
          $display("FAIL window_%0d: got %h c%0d r%0d l%b want %h c%0d r%0d l%b",
                   out_idx, win_data, win_col, win_row, win_last,
                   ref_win(out_idx), out_idx % W, out_idx / W, out_idx == N - 1);
        end
        if (out_idx >= N - W - 1) begin
          tests++;
          if (pixel_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: win=%0d got %b want 0", out_idx, pixel_in_ready);
          end
        end
        out_idx++;
        if (out_idx == N) begin
          frames_done++;
          n_acc = 0;
          out_idx = 0;
          ready_chk = 1'b1;
        end
      end else if (ready_chk) begin
        ready_chk = 1'b0;
        tests++;
        if (pixel_in_ready !== 1'b1) begin
          fails++;
          $display("FAIL ready_after_last: got %b want 1", pixel_in_ready);
        end
      end
      if (pixel_in_valid && pixel_in_ready && n_acc < N) begin
        img[n_acc] = pixel_in;
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
  end

  task automatic send(input logic [7:0] v, input bit gap);
    int t;
    t = 0;
    pixel_in = v;
    pixel_in_valid = 1'b1;
    @(negedge clk);
    while (!pixel_in_ready && t < TO) begin
      t++;
      @(negedge clk);
    end
    if (!pixel_in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: pixel %0d not accepted", v);
    end
    @(posedge clk);
    #1;
    if (gap) begin
      pixel_in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int k = 0; k < N; k++) send(8'(base + k + 1), gap);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < TO) begin
      @(posedge clk);
      t++;
    end
    tests++;
    if (frames_done < n) begin
      fails++;
      $display("FAIL frame_wait: frames got %0d want %0d", frames_done, n);
    end
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_frame(0, 1'b0);
    pixel_in_valid = 1'b0;
    wait_frames(1);
    chk("model_w11", ref_win(11), w9(7, 8, 0, 11, 12, 0, 0, 0, 0));
    chk("s1_w00", got[0], w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    chk("s1_w11", got[11], w9(7, 8, 0, 11, 12, 0, 0, 0, 0));
    chk("s2_w13", got[7], w9(3, 4, 0, 7, 8, 0, 11, 12, 0));
    chk("s2_w11", got[5], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("s2_w10", got[4], w9(0, 1, 2, 0, 5, 6, 0, 9, 10));

    send_frame(0, 1'b1);
    pixel_in_valid = 1'b0;
    wait_frames(2);
    chk("s3_w00", got[0], w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    chk("s3_w11", got[11], w9(7, 8, 0, 11, 12, 0, 0, 0, 0));

    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    pixel_in_valid = 1'b0;
    wait_frames(4);
    chk("s4_f2_w00", got[0], w9(0, 0, 0, 0, 101, 102, 0, 105, 106));
    chk("s4_f2_w11", got[11], w9(107, 108, 0, 111, 112, 0, 0, 0, 0));

    for (int k = 0; k < 8; k++) send(8'(k + 1), 1'b0);
    pixel_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < N; k++) got[k] = '0;
    send_frame(0, 1'b0);
    pixel_in_valid = 1'b0;
    wait_frames(5);
    chk("s5_w00", got[0], w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    chk("s5_w11", got[11], w9(7, 8, 0, 11, 12, 0, 0, 0, 0));
    chk("s5_w13", got[7], w9(3, 4, 0, 7, 8, 0, 11, 12, 0));
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
